// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared data-memory interface constants and types
package cpu_pkg;

  localparam int MEM_ADDR_W = 4;
  localparam int MEM_DATA_W = 16;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// rtl/dmem_arbiter_rr_pick.sv - combinational round-robin picker
// Returns the first set request at or after start, wrapping modulo N.
module rr_pick
  import cpu_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  always_comb begin
    logic [IDX_W-1:0] w_j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    w_j   = start;
    for (int k = 0; k < N; k++) begin
      if (!any && req[w_j]) begin
        any        = 1'b1;
        idx        = w_j;
        grant[w_j] = 1'b1;
      end
      // explicit wrap keeps non-power-of-two N correct
      w_j = (w_j == LAST_IDX) ? '0 : w_j + IDX_W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter with bounded lock for a single-port data RAM
// Grants one requester per cycle; the response strobe follows one cycle after the access.
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DATA_W   = MEM_DATA_W,
  parameter int LOCK_MAX = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  arb_state_t         r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic [CNT_W-1:0]   r_lock_cnt;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic               r_rsp_is_read;

  logic [IDX_W-1:0]   w_owner_next;
  logic [IDX_W-1:0]   w_start;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [IDX_W-1:0]   w_gidx;
  logic [NUM_REQ-1:0] w_pick_grant;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_pick_any;
  logic               w_any;
  logic               w_owner_hold;
  logic               w_we;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_wdata;

  assign w_owner_next = (r_owner == LAST_IDX) ? '0 : r_owner + IDX_W'(1);
  assign w_owner_hold = (r_state == LOCKED) && req_valid[r_owner];
  // on release the search starts just past the old owner so no cycle is lost
  assign w_start      = (r_state == LOCKED) ? w_owner_next : r_rr_ptr;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .start (w_start),
    .grant (w_pick_grant),
    .idx   (w_pick_idx),
    .any   (w_pick_any)
  );

  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_any   = 1'b0;
    if (!reset) begin
      if (w_owner_hold) begin
        w_grant[r_owner] = 1'b1;
        w_gidx           = r_owner;
        w_any            = 1'b1;
      end else begin
        w_grant = w_pick_grant;
        w_gidx  = w_pick_idx;
        w_any   = w_pick_any;
      end
    end
  end

  always_comb begin
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    if (w_any) begin
      w_we    = req_we[w_gidx];
      w_addr  = req_addr[int'(w_gidx)*ADDR_W +: ADDR_W];
      w_wdata = req_wdata[int'(w_gidx)*DATA_W +: DATA_W];
    end
  end

  assign req_ready = w_grant;
  assign mem_en    = w_any;
  assign mem_we    = w_we;
  assign mem_addr  = w_addr;
  assign mem_wdata = w_wdata;
  assign rsp_valid = reset ? '0 : r_rsp_valid;
  assign rsp_rdata = (!reset && r_rsp_is_read) ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ARB;
      r_rr_ptr      <= '0;
      r_owner       <= '0;
      r_lock_cnt    <= '0;
      r_rsp_valid   <= '0;
      r_rsp_is_read <= 1'b0;
    end else begin
      r_rsp_valid   <= w_grant;
      r_rsp_is_read <= w_any && !w_we;
      if (w_owner_hold) begin
        if (req_lock[r_owner] && (r_lock_cnt < LOCK_LAST)) begin
          r_lock_cnt <= r_lock_cnt + CNT_W'(1);
        end else begin
          r_state  <= ARB;
          r_rr_ptr <= w_owner_next;
        end
      end else begin
        if (r_state == LOCKED) begin
          r_state  <= ARB;
          r_rr_ptr <= w_owner_next;
        end
        if (w_any) begin
          if (req_lock[w_gidx] && (LOCK_MAX > 1)) begin
            r_state    <= LOCKED;
            r_owner    <= w_gidx;
            r_lock_cnt <= CNT_W'(1);
          end else begin
            r_rr_ptr <= (w_gidx == LAST_IDX) ? '0 : w_gidx + IDX_W'(1);
          end
        end
      end
    end
  end

endmodule
